multi_edge_detector: RTL

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

---
 rtl/multi_edge_detector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   WIDTH independent edge-detect channels. Each channel synchronises its raw
//   input, optionally debounces it, and reports the edges selected by its mode
//   as one-cycle strobes plus a sticky pending flag that software clears.
//
//   Optional feature macro: EDGE_DEBOUNCE_EN
//     undefined : the synchroniser output is accepted directly
//     defined   : a change must persist for DB_CYCLES enabled cycles first
//
//   Ports
//     MHz10       in   system clock
//     rst         in   synchronous active-high reset
//     en          in   sample enable (low freezes sampling, pulses forced low)
//     in          in   [WIDTH]   raw channel inputs
//     mode        in   [2*WIDTH] per-channel edge select, bits [2i+1:2i]
//                      00 off, 01 rising, 10 falling, 11 both
//     clr         in   [WIDTH]   per-channel pending clear
//     pulse       out  [WIDTH]   one-cycle edge strobes
//     pending     out  [WIDTH]   sticky event flags
//     any_pending out  OR of pending

module med_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       in_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       pulse_o,
  output logic       pending_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   pulse_q, pulse_d;
  logic                   pending_q, pending_d;
  logic                   sync_w, diff_w, accept_w;

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign diff_w = sync_w ^ stable_q;

  // Shift toward the MSB; the MSB is the synchronised value.
  always_comb begin
    sync_d = sync_q;
    if (en_i) sync_d = (sync_q << 1) | SYNC_STAGES'(in_i);
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // The count says how many enabled cycles the difference has already
  // persisted; acceptance happens on the DB_CYCLES-th consecutive cycle.
  always_comb begin
    cnt_d    = cnt_q;
    accept_w = 1'b0;
    if (en_i) begin
      if (!diff_w) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        accept_w = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign accept_w = en_i & diff_w;
`endif

  // stable follows every accepted edge even when the mode is off, so turning
  // a mode on later never reports a stale transition.
  always_comb begin
    stable_d  = accept_w ? sync_w : stable_q;
    pulse_d   = accept_w & (sync_w ? mode_i[0] : mode_i[1]);
    // A new event outranks a clear in the same cycle.
    pending_d = (pending_q & ~clr_i) | pulse_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      stable_q  <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign pending_o = pending_q;

endmodule

module multi_edge_detector #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                 MHz10,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     pulse,
  output logic [WIDTH-1:0]     pending,
  output logic                 any_pending
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    med_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_lane (
      .clk_i     (MHz10),
      .rst_i     (rst),
      .en_i      (en),
      .in_i      (in[i]),
      .mode_i    (mode[2*i+1:2*i]),
      .clr_i     (clr[i]),
      .pulse_o   (pulse[i]),
      .pending_o (pending[i])
    );
  end

  assign any_pending = |pending;

endmodule
